// File: rtl/instr_mem_loader.sv
// instr_mem_loader: field-loadable instruction memory on the CPU fetch path.
// Fetch side: one-cycle registered read of mem[pc]; NOP_WORD is returned for
// pc >= DEPTH and for every fetch while a load is running.
// Load side: byte stream (MSB byte first) written as whole words starting at
// a chosen base address, wrapping modulo DEPTH.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pc, fetch_en          fetch address and request qualifier
//   instr, instr_valid    registered fetch result
//   ld_start, ld_base,    start a load of ld_len words at ld_base
//   ld_len
//   ld_byte, ld_valid     load data stream
//   ld_ready, ld_busy     byte accept / load in progress
//   ld_done               one-cycle pulse when a load completes
module instr_mem_loader #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                done_d;
  logic                busy_d;
  logic                we_c;
  logic [DATA_W-1:0]   word_c;
  logic                pc_in_range_c;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  // Holding register shifted left with the incoming byte; low DATA_W bits
  // form the completed word on the last byte.
  assign word_c        = DATA_W'({hold_q, ld_byte});
  assign pc_in_range_c = {1'b0, pc} < CNT_W'(DEPTH);

  // Next-state and load datapath control.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    we_c    = 1'b0;
    case (state_q)
      RUN: begin
        if (ld_start) begin
          if (ld_len != '0) begin
            state_d = LOAD;
            ptr_d   = PTR_W'(32'(ld_base) % DEPTH);
            cnt_d   = ld_len;
            bidx_d  = '0;
            hold_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // ld_ready is constantly high in LOAD, so ld_valid alone transfers.
        if (ld_valid) begin
          if (bidx_q == BIDX_W'(BYTES - 1)) begin
            we_c   = 1'b1;
            hold_d = '0;
            bidx_d = '0;
            ptr_d  = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end else begin
            hold_d = word_c;
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign busy_d = (state_d == LOAD);

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      ptr_q    <= '0;
      cnt_q    <= '0;
      bidx_q   <= '0;
      hold_q   <= '0;
      ld_done  <= 1'b0;
      ld_busy  <= 1'b0;
      ld_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      bidx_q   <= bidx_d;
      hold_q   <= hold_d;
      ld_done  <= done_d;
      ld_busy  <= busy_d;
      ld_ready <= busy_d;
    end
  end

  // Memory array is not reset; a word in flight at reset is dropped.
  always_ff @(posedge clk) begin
    if (we_c && !reset) begin
      mem[ptr_q] <= word_c;
    end
  end

  // Registered fetch; NOPs are fed while a load is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
    end else if (state_q == LOAD) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= fetch_en;
      if (fetch_en) begin
        instr <= pc_in_range_c ? mem[PTR_W'(pc)] : NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: self-checking bench for instr_mem_loader.
// A second instance with DEPTH=512 shares all inputs for the out-of-range fetch.
module tb_instr_mem_loader;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1024;
  localparam logic [15:0] NOP   = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pc;
  logic        fetch_en;
  logic        ld_start;
  logic [9:0]  ld_base;
  logic [10:0] ld_len;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic [15:0] instr;
  logic        instr_valid, ld_ready, ld_busy, ld_done;
  logic [15:0] s_instr;
  logic        s_instr_valid, s_ready, s_busy, s_done;

  logic [15:0] model [DEPTH];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_mem_loader u_dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en),
    .instr(instr), .instr_valid(instr_valid),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_byte(ld_byte), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
  );

  instr_mem_loader #(.DEPTH(512)) u_dut512 (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en),
    .instr(s_instr), .instr_valid(s_instr_valid),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_byte(ld_byte), .ld_valid(ld_valid),
    .ld_ready(s_ready), .ld_busy(s_busy), .ld_done(s_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one fetch and return what the DUT shows after the edge.
  task automatic do_fetch(input int a, input bit en, output logic [15:0] i1, output logic v1);
    pc = AW'(a);
    fetch_en = en;
    tick();
    i1 = instr;
    v1 = instr_valid;
  endtask

  // Run a complete load and report observations; also updates the model.
  // gap: 0 = valid every cycle, 1 = valid every third cycle, 2 = random.
  task automatic drive_load(input int base, input int len, input logic [15:0] words [$],
                            input int gap, input bit restart,
                            output int cycles, output int rdy, output int bad,
                            output bit end_ok, output bit post_ok,
                            output logic [15:0] post_instr, output bit tmo);
    int sent;
    int total;
    bit acc;
    logic [15:0] w;
    total = len * 2;
    sent = 0; cycles = 0; rdy = 0; bad = 0; tmo = 0;
    fetch_en = 1'b1;
    ld_base = AW'(base);
    ld_len = 11'(len);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    while (sent < total) begin
      if (cycles >= 400) begin
        tmo = 1'b1;
        break;
      end
      w = words[sent / 2];
      ld_byte = (sent % 2 == 0) ? w[15:8] : w[7:0];
      case (gap)
        0:       ld_valid = 1'b1;
        1:       ld_valid = (cycles % 3 == 2);
        default: ld_valid = 1'($urandom_range(0, 1));
      endcase
      if (restart && cycles == 4) begin
        ld_start = 1'b1;
        ld_base = AW'(base + 7);
        ld_len = 11'(4);
      end
      acc = ld_valid && ld_ready;
      if (ld_ready === 1'b1) rdy++;
      tick();
      cycles++;
      ld_start = 1'b0;
      if (acc) sent++;
      if (instr !== NOP || instr_valid !== 1'b0) bad++;
      if (sent < total && (ld_busy !== 1'b1 || ld_done !== 1'b0)) bad++;
    end
    ld_valid = 1'b0;
    end_ok = (ld_done === 1'b1 && ld_busy === 1'b0 && ld_ready === 1'b0);
    for (int i = 0; i < len; i++) model[(base + i) % DEPTH] = words[i];
    pc = AW'(base % DEPTH);
    tick();
    post_ok = (ld_done === 1'b0 && ld_busy === 1'b0 && instr_valid === 1'b1);
    post_instr = instr;
  endtask

  task automatic test_reset();
    logic [15:0] i1;
    logic v1;
    reset = 1'b1; fetch_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    pc = '0; ld_base = '0; ld_len = '0; ld_byte = '0;
    tick();
    tick();
    n_cmp++;
    if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
    n_cmp++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_cmp++;
    if ({ld_ready, ld_busy, ld_done} !== 3'b000)
      begin n_fail++; $display("FAIL reset_ld_flags: got %b expected 000", {ld_ready, ld_busy, ld_done}); end
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      do_fetch(a, 1'b1, i1, v1);
      n_cmp++;
      if (i1 !== NOP || v1 !== 1'b1)
        begin n_fail++; $display("FAIL reset_fetch pc=%0d: got %h/%b expected %h/1", a, i1, v1, NOP); end
      n_cmp++;
      if ({ld_ready, ld_busy, ld_done} !== 3'b000)
        begin n_fail++; $display("FAIL idle_ld_flags pc=%0d: got %b expected 000", a, {ld_ready, ld_busy, ld_done}); end
    end
  endtask

  task automatic test_basic_load();
    logic [15:0] w [$];
    logic [15:0] exp_w [3];
    logic [15:0] i1, pi;
    logic v1;
    int cyc, rdy, bad;
    bit eok, pok, tmo;
    exp_w[0] = 16'h041A; exp_w[1] = 16'h082C; exp_w[2] = 16'h0C00;
    w = {16'h041A, 16'h082C, 16'h0C00};
    drive_load(0, 3, w, 0, 1'b0, cyc, rdy, bad, eok, pok, pi, tmo);
    n_cmp++;
    if (tmo || cyc != 6) begin n_fail++; $display("FAIL basic_cycles: got %0d (tmo=%0b) expected 6", cyc, tmo); end
    n_cmp++;
    if (rdy != 6) begin n_fail++; $display("FAIL basic_ready_cycles: got %0d expected 6", rdy); end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL basic_in_load: got %0d bad cycles expected 0", bad); end
    n_cmp++;
    if (!eok) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b ready=%b expected 1/0/0", ld_done, ld_busy, ld_ready); end
    n_cmp++;
    if (!pok || pi !== 16'h041A) begin n_fail++; $display("FAIL basic_post_fetch: got %h ok=%0b expected 041a ok=1", pi, pok); end
    for (int a = 0; a < 3; a++) begin
      do_fetch(a, 1'b1, i1, v1);
      n_cmp++;
      if (i1 !== exp_w[a] || v1 !== 1'b1)
        begin n_fail++; $display("FAIL basic_fetch pc=%0d: got %h/%b expected %h/1", a, i1, v1, exp_w[a]); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] w [$];
    logic [15:0] i1, pi;
    logic v1;
    int cyc, rdy, bad;
    bit eok, pok, tmo;
    w = {16'hAAAA, 16'hBBBB};
    drive_load(1023, 2, w, 0, 1'b0, cyc, rdy, bad, eok, pok, pi, tmo);
    n_cmp++;
    if (tmo || !eok || bad != 0) begin n_fail++; $display("FAIL wrap_load: got tmo=%0b end=%0b bad=%0d expected 0/1/0", tmo, eok, bad); end
    do_fetch(1023, 1'b1, i1, v1);
    n_cmp++;
    if (i1 !== 16'hAAAA || v1 !== 1'b1) begin n_fail++; $display("FAIL wrap_pc1023: got %h/%b expected aaaa/1", i1, v1); end
    do_fetch(0, 1'b1, i1, v1);
    n_cmp++;
    if (i1 !== 16'hBBBB) begin n_fail++; $display("FAIL wrap_pc0: got %h expected bbbb", i1); end
    do_fetch(1, 1'b1, i1, v1);
    n_cmp++;
    if (i1 !== 16'h082C) begin n_fail++; $display("FAIL wrap_pc1: got %h expected 082c", i1); end
  endtask

  task automatic test_gapped();
    logic [15:0] w [$];
    logic [15:0] exp_w [3];
    logic [15:0] i1, pi;
    logic v1;
    int cyc, rdy, bad;
    bit eok, pok, tmo;
    exp_w[0] = 16'h041A; exp_w[1] = 16'h082C; exp_w[2] = 16'h0C00;
    w = {16'h041A, 16'h082C, 16'h0C00};
    drive_load(200, 3, w, 1, 1'b1, cyc, rdy, bad, eok, pok, pi, tmo);
    n_cmp++;
    if (tmo || cyc != 18) begin n_fail++; $display("FAIL gap_cycles: got %0d (tmo=%0b) expected 18", cyc, tmo); end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL gap_nop_during_load: got %0d bad cycles expected 0", bad); end
    n_cmp++;
    if (!eok || !pok) begin n_fail++; $display("FAIL gap_done: got end=%0b post=%0b expected 1/1", eok, pok); end
    for (int a = 0; a < 3; a++) begin
      do_fetch(200 + a, 1'b1, i1, v1);
      n_cmp++;
      if (i1 !== exp_w[a]) begin n_fail++; $display("FAIL gap_fetch pc=%0d: got %h expected %h", 200 + a, i1, exp_w[a]); end
    end
    do_fetch(207, 1'b1, i1, v1);
    n_cmp++;
    if (i1 !== NOP) begin n_fail++; $display("FAIL gap_restart_ignored: got %h expected %h", i1, NOP); end
  endtask

  task automatic test_reset_midload();
    int base;
    logic [15:0] w0, w1, w2;
    logic [15:0] wq [$];
    logic [15:0] bytes [4];
    logic [15:0] i1, pi, old1;
    logic v1;
    int cyc, rdy, bad;
    bit eok, pok, tmo;
    base = $urandom_range(300, 900);
    w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
    old1 = model[base + 1];
    bytes[0] = {8'h00, w0[15:8]}; bytes[1] = {8'h00, w0[7:0]};
    bytes[2] = {8'h00, w1[15:8]}; bytes[3] = {8'h00, w1[7:0]};
    fetch_en = 1'b1;
    ld_base = AW'(base); ld_len = 11'(2); ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld_byte = bytes[k][7:0];
      ld_valid = 1'b1;
      tick();
    end
    ld_valid = 1'b0;
    model[base] = w0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({ld_ready, ld_busy, ld_done, instr_valid} !== 4'b0000 || instr !== NOP)
      begin n_fail++; $display("FAIL midreset_state: got flags %b instr %h expected 0000 %h",
                               {ld_ready, ld_busy, ld_done, instr_valid}, instr, NOP); end
    do_fetch(base, 1'b1, i1, v1);
    n_cmp++;
    if (i1 !== w0) begin n_fail++; $display("FAIL midreset_word0: got %h expected %h", i1, w0); end
    do_fetch(base + 1, 1'b1, i1, v1);
    n_cmp++;
    if (i1 !== old1) begin n_fail++; $display("FAIL midreset_word1: got %h expected %h", i1, old1); end
    wq = {w2};
    drive_load(base + 1, 1, wq, 0, 1'b0, cyc, rdy, bad, eok, pok, pi, tmo);
    n_cmp++;
    if (tmo || !eok || cyc != 2 || pi !== w2)
      begin n_fail++; $display("FAIL midreset_fresh_load: got %h cyc=%0d end=%0b expected %h cyc=2 end=1", pi, cyc, eok, w2); end
  endtask

  task automatic test_len_zero();
    logic [15:0] i1;
    logic v1;
    fetch_en = 1'b0;
    ld_base = AW'(5); ld_len = '0; ld_start = 1'b1;
    ld_byte = 8'hFF; ld_valid = 1'b1;
    tick();
    ld_start = 1'b0;
    n_cmp++;
    if ({ld_done, ld_busy, ld_ready} !== 3'b100)
      begin n_fail++; $display("FAIL len0_pulse: got %b expected 100", {ld_done, ld_busy, ld_ready}); end
    tick();
    ld_valid = 1'b0;
    n_cmp++;
    if ({ld_done, ld_busy} !== 2'b00) begin n_fail++; $display("FAIL len0_after: got %b expected 00", {ld_done, ld_busy}); end
    do_fetch(5, 1'b1, i1, v1);
    n_cmp++;
    if (i1 !== model[5] || v1 !== 1'b1) begin n_fail++; $display("FAIL len0_nowrite: got %h expected %h", i1, model[5]); end
  endtask

  task automatic test_fetch_en();
    logic [15:0] i1;
    logic v1;
    do_fetch(201, 1'b1, i1, v1);
    n_cmp++;
    if (i1 !== 16'h082C || v1 !== 1'b1) begin n_fail++; $display("FAIL fen_on: got %h/%b expected 082c/1", i1, v1); end
    do_fetch(1023, 1'b0, i1, v1);
    n_cmp++;
    if (i1 !== 16'h082C || v1 !== 1'b0) begin n_fail++; $display("FAIL fen_hold: got %h/%b expected 082c/0", i1, v1); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] i1;
    logic v1;
    do_fetch(600, 1'b1, i1, v1);
    n_cmp++;
    if (s_instr !== NOP || s_instr_valid !== 1'b1)
      begin n_fail++; $display("FAIL oor_pc600: got %h/%b expected %h/1", s_instr, s_instr_valid, NOP); end
    n_cmp++;
    if (i1 !== model[600]) begin n_fail++; $display("FAIL inrange_pc600: got %h expected %h", i1, model[600]); end
    do_fetch(1023, 1'b1, i1, v1);
    n_cmp++;
    if (s_instr !== NOP || {s_ready, s_busy, s_done} !== 3'b000)
      begin n_fail++; $display("FAIL oor_pc1023: got %h flags %b expected %h 000", s_instr, {s_ready, s_busy, s_done}, NOP); end
  endtask

  task automatic test_random();
    logic [15:0] w [$];
    logic [15:0] i1, pi;
    logic v1;
    int base, len, cyc, rdy, bad, a;
    bit eok, pok, tmo;
    for (int n = 0; n < 6; n++) begin
      base = $urandom_range(0, 1023);
      len = $urandom_range(1, 5);
      w.delete();
      for (int k = 0; k < len; k++) w.push_back(16'($urandom));
      drive_load(base, len, w, 2 * int'($urandom_range(0, 1)), 1'b0, cyc, rdy, bad, eok, pok, pi, tmo);
      n_cmp++;
      if (tmo || !eok || !pok || bad != 0 || pi !== model[base])
        begin n_fail++; $display("FAIL rand_load base=%0d len=%0d: got %h end=%0b post=%0b bad=%0d tmo=%0b expected %h 1 1 0 0",
                                 base, len, pi, eok, pok, bad, tmo, model[base]); end
    end
    for (int n = 0; n < 30; n++) begin
      a = $urandom_range(0, 1023);
      do_fetch(a, 1'b1, i1, v1);
      n_cmp++;
      if (i1 !== model[a] || v1 !== 1'b1)
        begin n_fail++; $display("FAIL rand_fetch pc=%0d: got %h/%b expected %h/1", a, i1, v1, model[a]); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    test_reset();
    test_basic_load();
    test_wrap();
    test_gapped();
    test_reset_midload();
    test_len_zero();
    test_fetch_en();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
